// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives J/K/Enable of an external JK bank toward a target word with check and retry
module jk_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter int SETTLE     = 2,
  parameter int MAX_RETRY  = 1,
  parameter int USE_TOGGLE = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Target_Data,
  input  logic             Target_Valid,
  output logic             Target_Ready,
  input  logic [WIDTH-1:0] Q_In,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Enable,
  output logic             Done,
  output logic             Error,
  output logic [WIDTH-1:0] Mismatch
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SETTLE, ST_CHECK} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] target_q;
  logic [RW-1:0]    retry_q;
  logic [CW-1:0]    settle_q;
  logic [WIDTH-1:0] j_q, k_q, mismatch_q;
  logic             en_q, done_q, error_q;

  // In IDLE the excitation is built from the incoming word, otherwise from the latched target.
  logic [WIDTH-1:0] exc_t, j_d, k_d;
  assign exc_t = (state_q == ST_IDLE) ? Target_Data : target_q;
  assign j_d   = (USE_TOGGLE != 0) ? (exc_t ^ Q_In) : (exc_t & ~Q_In);
  assign k_d   = (USE_TOGGLE != 0) ? (exc_t ^ Q_In) : (Q_In & ~exc_t);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      retry_q    <= '0;
      settle_q   <= '0;
      j_q        <= '0;
      k_q        <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mismatch_q <= '0;
    end else begin
      j_q     <= '0;
      k_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Target_Valid) begin
            target_q   <= Target_Data;
            retry_q    <= '0;
            mismatch_q <= '0;
            if (Q_In == Target_Data) begin
              done_q <= 1'b1;
            end else begin
              j_q     <= j_d;
              k_q     <= k_d;
              en_q    <= 1'b1;
              state_q <= ST_APPLY;
            end
          end
        end
        ST_APPLY: begin
          settle_q <= CW'(SETTLE - 1);
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == '0) state_q <= ST_CHECK;
          else                settle_q <= settle_q - CW'(1);
        end
        ST_CHECK: begin
          if (Q_In == target_q) begin
            done_q     <= 1'b1;
            mismatch_q <= '0;
            state_q    <= ST_IDLE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_q <= retry_q + RW'(1);
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= 1'b1;
            state_q <= ST_APPLY;
          end else begin
            done_q     <= 1'b1;
            error_q    <= 1'b1;
            mismatch_q <= Q_In ^ target_q;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Target_Ready = (state_q == ST_IDLE);
  assign J            = j_q;
  assign K            = k_q;
  assign Enable       = en_q;
  assign Done         = done_q;
  assign Error        = error_q;
  assign Mismatch     = mismatch_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - self-checking bench for jk_excitation_driver with behavioural JK banks
module tb_jk_excitation_driver;
  localparam int S = 2;
  localparam int R = 1;

  typedef struct {
    logic [7:0] start, tgt, stuck, j, k, jt, mm;
    int         lat, nen;
    logic       err;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Target_Data;
  logic       Target_Valid;
  logic       Ready0, Ready1, Enable0, Enable1, Done0, Done1, Error0, Error1;
  logic [7:0] J0, K0, J1, K1, Mm0, Mm1, bank0, bank1;
  logic       load_en;
  logic [7:0] load_val;
  logic [7:0] stuck_mask = 8'h00;
  logic       en_prev0 = 1'b0, en_prev1 = 1'b0;
  int         total = 0, bad = 0;

  always #5 Clock = ~Clock;

  jk_excitation_driver #(.WIDTH(8), .SETTLE(S), .MAX_RETRY(R), .USE_TOGGLE(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Target_Data(Target_Data), .Target_Valid(Target_Valid),
    .Target_Ready(Ready0), .Q_In(bank0), .J(J0), .K(K0), .Enable(Enable0),
    .Done(Done0), .Error(Error0), .Mismatch(Mm0));

  jk_excitation_driver #(.WIDTH(8), .SETTLE(S), .MAX_RETRY(R), .USE_TOGGLE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Target_Data(Target_Data), .Target_Valid(Target_Valid),
    .Target_Ready(Ready1), .Q_In(bank1), .J(J1), .K(K1), .Enable(Enable1),
    .Done(Done1), .Error(Error1), .Mismatch(Mm1));

  // JK bank: Q+ = J&~Q | ~K&Q when enabled; stuck bits are forced low.
  always @(posedge Clock) begin
    if (load_en) begin
      bank0 <= load_val & ~stuck_mask;
      bank1 <= load_val & ~stuck_mask;
    end else begin
      bank0 <= (Enable0 ? ((J0 & ~bank0) | (~K0 & bank0)) : bank0) & ~stuck_mask;
      bank1 <= (Enable1 ? ((J1 & ~bank1) | (~K1 & bank1)) : bank1) & ~stuck_mask;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      if ((Enable0 === 1'b1 && en_prev0) || (Enable0 !== 1'b1 && (J0 | K0) !== 8'h00))
        chk("enable_rule0", 1, 0);
      if ((Enable1 === 1'b1 && en_prev1) || (Enable1 !== 1'b1 && (J1 | K1) !== 8'h00))
        chk("enable_rule1", 1, 0);
    end
    en_prev0 = (Enable0 === 1'b1);
    en_prev1 = (Enable1 === 1'b1);
  end

  function automatic vec_t model(input logic [7:0] s, input logic [7:0] t, input logic [7:0] m);
    vec_t v;
    logic [7:0] eff, fin;
    logic changed, ok;
    eff = s & ~m;
    fin = t & ~m;
    changed = (eff != t);
    ok = (fin == t);
    v.start = s; v.tgt = t; v.stuck = m;
    v.j = t & ~eff; v.k = eff & ~t; v.jt = t ^ eff;
    if (!changed) begin v.lat = 1; v.nen = 0; end
    else if (ok) begin v.lat = S + 3; v.nen = 1; end
    else begin v.lat = S + 3 + R * (S + 2); v.nen = R + 1; end
    v.err = changed && !ok;
    v.mm = v.err ? (t ^ fin) : 8'h00;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int lat0, lat1, n0, n1;
    logic [7:0] fj, fk, fjt, fkt, mm_at, bank_at;
    logic err0_at, err1_at;
    lat0 = 0; lat1 = 0; n0 = 0; n1 = 0;
    fj = 0; fk = 0; fjt = 0; fkt = 0; mm_at = 0; bank_at = 0; err0_at = 0; err1_at = 0;
    @(negedge Clock); load_en = 1'b1; load_val = v.start; stuck_mask = v.stuck;
    @(negedge Clock); load_en = 1'b0; Target_Valid = 1'b1; Target_Data = v.tgt;
    @(posedge Clock); #1;
    Target_Valid = 1'b0; Target_Data = 8'($urandom);
    chk($sformatf("%s mm_clear", tag), Mm0, 0);
    for (int c = 1; c <= 30 && lat0 == 0; c++) begin
      if (c > 1) begin @(posedge Clock); #1; end
      if (Enable0) begin if (n0 == 0) begin fj = J0; fk = K0; end n0++; end
      if (Enable1) begin if (n1 == 0) begin fjt = J1; fkt = K1; end n1++; end
      if (Done1 && lat1 == 0) begin lat1 = c; err1_at = Error1; end
      if (Done0) begin lat0 = c; err0_at = Error0; mm_at = Mm0; bank_at = bank0; end
    end
    chk($sformatf("%s latency", tag), lat0, v.lat);
    chk($sformatf("%s error", tag), err0_at, v.err);
    chk($sformatf("%s mismatch", tag), mm_at, v.mm);
    chk($sformatf("%s bank", tag), bank_at, v.tgt & ~v.stuck);
    chk($sformatf("%s enables", tag), n0, v.nen);
    chk($sformatf("%s tgl_latency", tag), lat1, v.lat);
    chk($sformatf("%s tgl_error", tag), err1_at, v.err);
    if (v.nen > 0) begin
      chk($sformatf("%s j", tag), fj, v.j);
      chk($sformatf("%s k", tag), fk, v.k);
      chk($sformatf("%s tgl_j", tag), fjt, v.jt);
      chk($sformatf("%s tgl_k", tag), fkt, v.jt);
    end
    @(posedge Clock); #1;
    chk($sformatf("%s done_pulse", tag), Done0, 0);
    chk($sformatf("%s mm_hold", tag), Mm0, v.mm);
  endtask

  vec_t vecs[6];

  initial begin
    int dcount, ecount;
    vecs[0] = '{start:8'h00, tgt:8'hA5, stuck:8'h00, j:8'hA5, k:8'h00, jt:8'hA5, mm:8'h00, lat:5, nen:1, err:1'b0};
    vecs[1] = '{start:8'hA5, tgt:8'h3C, stuck:8'h00, j:8'h18, k:8'h81, jt:8'h99, mm:8'h00, lat:5, nen:1, err:1'b0};
    vecs[2] = '{start:8'h3C, tgt:8'h3C, stuck:8'h00, j:8'h00, k:8'h00, jt:8'h00, mm:8'h00, lat:1, nen:0, err:1'b0};
    vecs[3] = '{start:8'h00, tgt:8'h01, stuck:8'h01, j:8'h01, k:8'h00, jt:8'h01, mm:8'h01, lat:9, nen:2, err:1'b1};
    vecs[4] = '{start:8'h00, tgt:8'h80, stuck:8'h00, j:8'h80, k:8'h00, jt:8'h80, mm:8'h00, lat:5, nen:1, err:1'b0};
    vecs[5] = '{start:8'hF0, tgt:8'h0F, stuck:8'h00, j:8'h0F, k:8'hF0, jt:8'hFF, mm:8'h00, lat:5, nen:1, err:1'b0};

    Reset = 1'b1; Target_Valid = 1'b1; Target_Data = 8'h55; load_en = 1'b1; load_val = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      chk("rst_j", J0, 0); chk("rst_k", K0, 0); chk("rst_en", Enable0, 0);
      chk("rst_done", Done0, 0); chk("rst_mm", Mm0, 0);
    end
    @(negedge Clock); Reset = 1'b0; Target_Valid = 1'b0; load_en = 1'b0;
    @(posedge Clock); #1;
    chk("rst_ready", Ready0, 1);
    chk("rst_no_accept", Done0, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Busy request is ignored, then reset aborts mid-settle.
    @(negedge Clock); load_en = 1'b1; load_val = 8'h00; stuck_mask = 8'h00;
    @(negedge Clock); load_en = 1'b0; Target_Valid = 1'b1; Target_Data = 8'hF0;
    @(posedge Clock); #1; Target_Valid = 1'b0;
    @(posedge Clock); #1;
    chk("busy_ready", Ready0, 0);
    @(negedge Clock); Target_Valid = 1'b1; Target_Data = 8'hFF;
    @(posedge Clock); #1;
    chk("busy_ready2", Ready0, 0);
    chk("busy_en", Enable0, 0);
    @(negedge Clock); Target_Valid = 1'b0; Reset = 1'b1;
    @(posedge Clock); #1;
    chk("abort_en", Enable0, 0); chk("abort_j", J0, 0); chk("abort_k", K0, 0);
    chk("abort_done", Done0, 0);
    @(negedge Clock); Reset = 1'b0;
    dcount = 0; ecount = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock); #1;
      if (Done0) dcount++;
      if (Enable0) ecount++;
    end
    chk("abort_ready", Ready0, 1);
    chk("abort_no_done", dcount, 0);
    chk("abort_no_enable", ecount, 0);
    chk("abort_bank", bank0, 8'hF0);
    run_vec(vecs[5], "after_abort");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] s, t, m;
      s = 8'($urandom);
      t = 8'($urandom);
      m = (i % 4 == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if (i % 5 == 0) t = s & ~m;
      run_vec(model(s, t, m), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
